// File: rtl/gf8_reduce_seq_if.sv
// Handshake bundle between the carry-less multiplier, the GF(2^8) reducer and its consumer.
// master drives products and consumes results; slave is the reducer.
interface gf8_reduce_seq_if;
  logic        in_valid;
  logic        in_ready;
  logic [14:0] in_prod;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  out_res;
  logic        busy;

  modport master (
    output in_valid, in_prod, out_ready,
    input  in_ready, out_valid, out_res, busy
  );

  modport slave (
    input  in_valid, in_prod, out_ready,
    output in_ready, out_valid, out_res, busy
  );
endinterface

// File: rtl/gf8_reduce_seq.sv
// Bit-serial reduction of a 15-bit carry-less product modulo POLY, one coefficient per cycle, MSB first.
// Fixed 7-cycle latency from accept to out_valid; in_ready low while busy, result held until out_ready.
module gf8_reduce_seq #(
  parameter logic [8:0] POLY = 9'h11B
) (
  input logic             clk,
  input logic             rst,
  gf8_reduce_seq_if.slave bus
);
  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [14:0] r_rem;
  logic [14:0] w_rem_nxt;
  logic [14:0] w_fold;
  logic [14:0] w_poly_sh;
  logic [2:0]  r_cnt;
  logic [2:0]  w_cnt_nxt;
  logic [3:0]  w_bit;

  if (!POLY[8]) begin : g_poly_chk
    $error("gf8_reduce_seq: POLY must be of degree 8 (POLY[8] = 1)");
  end

  // Fold target is coefficient 8+cnt; XOR-ing the shifted modulus clears it.
  assign w_bit     = {1'b1, r_cnt};
  assign w_poly_sh = {6'd0, POLY} << r_cnt;
  assign w_fold    = r_rem[w_bit] ? (r_rem ^ w_poly_sh) : r_rem;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_rem   <= '0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_rem   <= w_rem_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_rem_nxt     = r_rem;
    w_cnt_nxt     = r_cnt;
    bus.in_ready  = 1'b0;
    bus.out_valid = 1'b0;
    bus.busy      = 1'b0;
    case (r_state)
      S_IDLE: begin
        bus.in_ready = 1'b1;
        if (bus.in_valid) begin
          w_rem_nxt   = bus.in_prod;
          w_cnt_nxt   = 3'd6;
          w_state_nxt = S_RUN;
        end
      end
      S_RUN: begin
        bus.busy  = 1'b1;
        w_rem_nxt = w_fold;
        if (r_cnt == 3'd0) begin
          w_state_nxt = S_DONE;
        end else begin
          w_cnt_nxt = r_cnt - 3'd1;
        end
      end
      S_DONE: begin
        bus.busy      = 1'b1;
        bus.out_valid = 1'b1;
        if (bus.out_ready) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
    // Handshake outputs are forced quiet for the whole reset cycle, not just after the edge.
    if (rst) begin
      bus.in_ready  = 1'b0;
      bus.out_valid = 1'b0;
      bus.busy      = 1'b0;
    end
  end

  assign bus.out_res = r_rem[7:0];

  always_ff @(posedge clk) begin
    if (!rst && r_state == S_RUN && r_cnt == 3'd0) begin
      assert (w_fold[14:8] == 7'd0)
        else $error("gf8_reduce_seq: high coefficients not cleared entering DONE");
    end
  end
endmodule

// File: tb/tb_gf8_reduce_seq.sv
// Directed bench for gf8_reduce_seq: reference reducer built from x^k mod POLY, cycle-level timing model, per-cycle compare.
module tb_gf8_reduce_seq;
  localparam logic [8:0] POLY = 9'h11B;

  logic clk;
  logic rst;
  gf8_reduce_seq_if bus();

  gf8_reduce_seq #(.POLY(POLY)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: the result is linear in the product bits, so XOR together x^k mod POLY for every set bit k.
  function automatic logic [7:0] gf_red(input logic [14:0] p);
    logic [7:0] t;
    logic [7:0] acc;
    t   = 8'h01;
    acc = 8'h00;
    for (int k = 0; k < 15; k++) begin
      if (p[k]) acc = acc ^ t;
      t = {t[6:0], 1'b0} ^ (t[7] ? POLY[7:0] : 8'h00);
    end
    return acc;
  endfunction

  // Timing model: idle, then 7 cycles of work, then a held result until consumed.
  int         cyc = 0;
  int         m_cnt = 0;
  bit         m_done = 1'b0;
  logic [7:0] m_exp = 8'h00;
  int         m_results = 0;
  int         dut_hs = 0;
  int         acc_q[$];

  always @(posedge clk) begin
    cyc++;
    if (!rst && bus.out_valid && bus.out_ready) dut_hs++;
    if (rst) begin
      m_cnt  = 0;
      m_done = 1'b0;
    end else if (m_done) begin
      if (bus.out_ready) begin
        m_done = 1'b0;
        m_results++;
      end
    end else if (m_cnt != 0) begin
      m_cnt--;
      if (m_cnt == 0) m_done = 1'b1;
    end else if (bus.in_valid) begin
      m_cnt = 7;
      m_exp = gf_red(bus.in_prod);
      acc_q.push_back(cyc);
    end
  end

  always @(negedge clk) begin
    #2;
    if (cyc >= 1) begin
      chk("out_valid", 16'(bus.out_valid), 16'(m_done && !rst));
      chk("in_ready",  16'(bus.in_ready),  16'(!m_done && m_cnt == 0 && !rst));
      chk("busy",      16'(bus.busy),      16'((m_done || m_cnt != 0) && !rst));
      if (m_done && !rst) chk("out_res", 16'(bus.out_res), 16'(m_exp));
    end
  end

  // Entered just after a negedge; returns at the negedge following the accepting edge.
  task automatic send(input logic [14:0] p);
    bus.in_valid = 1'b1;
    bus.in_prod  = p;
    for (int i = 0; i < 40 && !bus.in_ready; i++) @(negedge clk);
    chk("send_ready", 16'(bus.in_ready), 16'd1);
    @(negedge clk);
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_out(output int n);
    n = 0;
    while (!bus.out_valid && n < 30) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic run_one(input string name, input logic [14:0] p, input logic [7:0] exp);
    int n;
    send(p);
    wait_out(n);
    chk({name, "_lat"}, 16'(n), 16'd7);
    chk({name, "_res"}, 16'(bus.out_res), 16'(exp));
    @(negedge clk);
  endtask

  initial begin
    int n;
    int base;
    int hs0;
    logic [7:0] held;

    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_prod   = '0;
    bus.out_ready = 1'b1;

    chk("model_aes",  16'(gf_red(15'h3F7E)), 16'h01);
    chk("model_ones", 16'(gf_red(15'h5555)), 16'h13);
    chk("model_low",  16'(gf_red(15'h00FF)), 16'hFF);
    chk("model_x8",   16'(gf_red(15'h0100)), 16'h1B);

    repeat (3) @(negedge clk);
    chk("rst_out_res",   16'(bus.out_res),   16'h00);
    chk("rst_in_ready",  16'(bus.in_ready),  16'd0);
    chk("rst_out_valid", 16'(bus.out_valid), 16'd0);
    chk("rst_busy",      16'(bus.busy),      16'd0);
    rst = 1'b0;
    #1;
    chk("post_rst_in_ready", 16'(bus.in_ready), 16'd1);
    @(negedge clk);

    run_one("aes",  15'h3F7E, 8'h01);
    run_one("ones", 15'h5555, 8'h13);
    run_one("low",  15'h00FF, 8'hFF);

    // Output backpressure
    bus.out_ready = 1'b0;
    send(15'h1234);
    wait_out(n);
    chk("bp_lat", 16'(n), 16'd7);
    held = bus.out_res;
    chk("bp_res", 16'(held), 16'(gf_red(15'h1234)));
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_hold_res",   16'(bus.out_res),   16'(held));
      chk("bp_hold_valid", 16'(bus.out_valid), 16'd1);
      chk("bp_in_ready",   16'(bus.in_ready),  16'd0);
      chk("bp_busy",       16'(bus.busy),      16'd1);
    end
    bus.out_ready = 1'b1;
    @(negedge clk);
    chk("bp_release_valid", 16'(bus.out_valid), 16'd0);
    chk("bp_release_ready", 16'(bus.in_ready),  16'd1);

    // Input pulse while running must be ignored
    send(15'h3F7E);
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_prod  = 15'h7FFF;
    @(negedge clk);
    bus.in_valid = 1'b0;
    hs0 = dut_hs;
    wait_out(n);
    chk("busy_in_res", 16'(bus.out_res), 16'h01);
    repeat (15) @(negedge clk);
    chk("busy_in_single", 16'(dut_hs - hs0), 16'd1);

    // Back-to-back with in_valid held high
    base = acc_q.size();
    bus.in_valid = 1'b1;
    for (int k = 0; k < 100; k++) begin
      bus.in_prod = 15'($urandom);
      for (int i = 0; i < 30 && !bus.in_ready; i++) @(negedge clk);
      chk("b2b_ready", 16'(bus.in_ready), 16'd1);
      @(negedge clk);
    end
    bus.in_valid = 1'b0;
    repeat (12) @(negedge clk);
    chk("b2b_accepts", 16'(acc_q.size() - base), 16'd100);
    for (int i = base + 1; i < acc_q.size(); i++) begin
      chk("b2b_ii", 16'(acc_q[i] - acc_q[i-1]), 16'd9);
    end

    // Reset landing on the E4 fold
    hs0 = dut_hs;
    send(15'h5555);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("midrst_in_ready", 16'(bus.in_ready), 16'd1);
    repeat (15) @(negedge clk);
    chk("midrst_no_result", 16'(dut_hs - hs0), 16'd0);
    run_one("after_rst", 15'h3F7E, 8'h01);
    repeat (3) @(negedge clk);

    chk("total_results", 16'(m_results), 16'd106);
    chk("dut_handshakes", 16'(dut_hs), 16'(m_results));

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end
endmodule
